fpga_verif_sequencer: RTL and testbench

Synthesizable stimulus-and-check controller for the fabric's formal-verification wrapper. It drives pseudo-random vectors onto the mapped design's inputs, compares the FPGA outputs against the golden reference netlist over a fixed window, and reports an error-event count with pass/done status. It enables on-silicon or emulated self-test of a programmed fabric, alongside the `_formal_verification` wrapper and the reference design.

---
 rtl/fpga_verif_pkg.sv | 15 +
 rtl/verif_lfsr.sv | 39 +++
 rtl/fpga_verif_sequencer.sv | 141 ++++++++++++++
 tb/tb_fpga_verif_sequencer.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/fpga_verif_pkg.sv
// Shared types and constants for the fabric self-test sequencer.
package fpga_verif_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WARMUP = 2'd1,
        ST_RUN    = 2'd2,
        ST_DONE   = 2'd3
    } seq_state_e;

    localparam int          LFSR_W       = 32;
    localparam logic [31:0] LFSR_TAPS    = 32'h8020_0003;
    localparam logic [31:0] DEFAULT_SEED = 32'h0000_0001;

endpackage

// File: rtl/verif_lfsr.sv
// 32-bit right-shifting Galois LFSR with load, advance and a zero-seed guard.
module verif_lfsr
    import fpga_verif_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED  = DEFAULT_SEED,
    parameter int                OUT_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic             adv_i,
    output logic [OUT_W-1:0] state_o
);

    // An all-zero state would lock the register, so a zero seed becomes 1.
    localparam logic [LFSR_W-1:0] SEED_SAFE = (SEED == '0) ? LFSR_W'(1) : SEED;

    logic [LFSR_W-1:0] lfsr_q, lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (load_i) begin
            lfsr_d = SEED_SAFE;
        end else if (adv_i) begin
            lfsr_d = (lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_TAPS : '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= '0;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign state_o = lfsr_q[OUT_W-1:0];

endmodule

// File: rtl/fpga_verif_sequencer.sv
// Stimulus-and-check controller for the fabric formal-verification wrapper.
// Optional first-error capture is enabled by defining FPGA_VERIF_FIRST_ERR_EN.
module fpga_verif_sequencer
    import fpga_verif_pkg::*;
#(
    parameter int          N_IN          = 2,
    parameter int          N_OUT         = 1,
    parameter int          WARMUP_CYCLES = 1,
    parameter int          RUN_CYCLES    = 400,
    parameter logic [31:0] SEED          = DEFAULT_SEED,
    parameter int          ERR_W         = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic [N_IN-1:0]  stim_o,
    input  logic [N_OUT-1:0] dut_out_i,
    input  logic [N_OUT-1:0] ref_out_i,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             mismatch_o,
    output logic [ERR_W-1:0] err_count,
    output logic [15:0]      first_err_cycle,
    output logic [N_OUT-1:0] first_err_dut,
    output logic [N_OUT-1:0] first_err_ref
);

    seq_state_e       state_q;
    logic [31:0]      cyc_q;
    logic             busy_q, done_q, pass_q, mismatch_q;
    logic [ERR_W-1:0] err_q, err_d;

    logic start_ok, mm_now, event_now, lfsr_adv;

    assign start_ok  = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign lfsr_adv  = (state_q == ST_WARMUP) || (state_q == ST_RUN);
    assign mm_now    = |(dut_out_i ^ ref_out_i);
    // Only the 0->1 transition of the registered compare is an error event.
    assign event_now = (state_q == ST_RUN) && mm_now && !mismatch_q;
    assign err_d     = (err_q == '1) ? err_q : err_q + ERR_W'(1);

    verif_lfsr #(
        .SEED  (SEED),
        .OUT_W (N_IN)
    ) u_lfsr (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (start_ok),
        .adv_i   (lfsr_adv),
        .state_o (stim_o)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cyc_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            mismatch_q <= 1'b0;
            err_q      <= '0;
        end else if (start_ok) begin
            state_q    <= ST_WARMUP;
            cyc_q      <= '0;
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            mismatch_q <= 1'b0;
            err_q      <= '0;
        end else begin
            case (state_q)
                ST_WARMUP: begin
                    if (cyc_q == 32'(WARMUP_CYCLES - 1)) begin
                        state_q <= ST_RUN;
                        cyc_q   <= '0;
                    end else begin
                        cyc_q <= cyc_q + 32'd1;
                    end
                end
                ST_RUN: begin
                    mismatch_q <= mm_now;
                    if (event_now) begin
                        err_q <= err_d;
                    end
                    // The last compare's event is folded into pass here.
                    if (cyc_q == 32'(RUN_CYCLES - 1)) begin
                        state_q <= ST_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        pass_q  <= (err_q == '0) && !event_now;
                    end else begin
                        cyc_q <= cyc_q + 32'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign pass       = pass_q;
    assign mismatch_o = mismatch_q;
    assign err_count  = err_q;

`ifdef FPGA_VERIF_FIRST_ERR_EN
    logic             captured_q;
    logic [15:0]      fec_q;
    logic [N_OUT-1:0] fdut_q, fref_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            captured_q <= 1'b0;
            fec_q      <= '0;
            fdut_q     <= '0;
            fref_q     <= '0;
        end else if (start_ok) begin
            captured_q <= 1'b0;
            fec_q      <= '0;
            fdut_q     <= '0;
            fref_q     <= '0;
        end else if (event_now && !captured_q) begin
            captured_q <= 1'b1;
            fec_q      <= (cyc_q > 32'h0000_FFFF) ? 16'hFFFF : cyc_q[15:0];
            fdut_q     <= dut_out_i;
            fref_q     <= ref_out_i;
        end
    end

    assign first_err_cycle = fec_q;
    assign first_err_dut   = fdut_q;
    assign first_err_ref   = fref_q;
`else
    assign first_err_cycle = '0;
    assign first_err_dut   = '0;
    assign first_err_ref   = '0;
`endif

endmodule

// File: tb/tb_fpga_verif_sequencer.sv
// Scoreboard bench for fpga_verif_sequencer: default instance plus an ERR_W=2, SEED=0 instance.
module tb_fpga_verif_sequencer;

    localparam int W = 1;
    localparam int R = 400;

    logic clk = 1'b0;
    logic rst_n;
    logic start_a, start_b, inj_a, inj_b;

    logic [1:0]  stim_a, stim_b;
    logic        ref_a, ref_b, dut_a, dut_b;
    logic        busy_a, busy_b, done_a, done_b, pass_a, pass_b, mm_a, mm_b;
    logic [15:0] err_a;
    logic [1:0]  err_b;
    logic [15:0] fec_a, fec_b;
    logic        fdut_a, fdut_b, fref_a, fref_b;

    int n_chk  = 0;
    int n_fail = 0;
    logic mm_q[$];

    always #5 clk = ~clk;

    assign ref_a = ^stim_a;
    assign ref_b = ^stim_b;
    assign dut_a = ref_a ^ inj_a;
    assign dut_b = ref_b ^ inj_b;

    fpga_verif_sequencer #(
        .N_IN(2), .N_OUT(1), .WARMUP_CYCLES(W), .RUN_CYCLES(R),
        .SEED(32'h0000_0001), .ERR_W(16)
    ) u_dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .stim_o(stim_a),
        .dut_out_i(dut_a), .ref_out_i(ref_a), .busy(busy_a), .done(done_a),
        .pass(pass_a), .mismatch_o(mm_a), .err_count(err_a),
        .first_err_cycle(fec_a), .first_err_dut(fdut_a), .first_err_ref(fref_a)
    );

    fpga_verif_sequencer #(
        .N_IN(2), .N_OUT(1), .WARMUP_CYCLES(W), .RUN_CYCLES(R),
        .SEED(32'h0000_0000), .ERR_W(2)
    ) u_dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .stim_o(stim_b),
        .dut_out_i(dut_b), .ref_out_i(ref_b), .busy(busy_b), .done(done_b),
        .pass(pass_b), .mismatch_o(mm_b), .err_count(err_b),
        .first_err_cycle(fec_b), .first_err_dut(fdut_b), .first_err_ref(fref_b)
    );

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        logic [31:0] n;
        n = s >> 1;
        if (s[0]) n = n ^ 32'h8020_0003;
        return n;
    endfunction

    function automatic logic inj_for(input int mode, input int idx);
        case (mode)
            1:       return (idx >= 10) && (idx <= 12);
            2:       return (idx == 5) || (idx == 20);
            3:       return (idx % 2) == 0;
            default: return 1'b0;
        endcase
    endfunction

    task automatic check_reset(input string tag);
        check_val({tag, "_stim"}, 32'(stim_a), 32'd0);
        check_val({tag, "_busy"}, 32'(busy_a), 32'd0);
        check_val({tag, "_done"}, 32'(done_a), 32'd0);
        check_val({tag, "_pass"}, 32'(pass_a), 32'd0);
        check_val({tag, "_mm"},   32'(mm_a),   32'd0);
        check_val({tag, "_err"},  32'(err_a),  32'd0);
        check_val({tag, "_fec"},  32'(fec_a),  32'd0);
        check_val({tag, "_fdut"}, 32'(fdut_a), 32'd0);
        check_val({tag, "_fref"}, 32'(fref_a), 32'd0);
    endtask

    // One run on instance inst; pulse_at/rst_at are bench cycle indices (-1 = never).
    task automatic run(input string tag, input int inst, input int mode,
                       input int pulse_at, input int rst_at);
        logic [31:0] m;
        int          busy_n, exp_err, errmax, first_idx, idx;
        logic        prev, inj, refv, e_fd, e_fr, obs_busy;
        logic [31:0] e_fec;
        errmax    = (inst == 0) ? 65535 : 3;
        m         = 32'h1;
        busy_n    = 0;
        exp_err   = 0;
        prev      = 1'b0;
        first_idx = -1;
        e_fd      = 1'b0;
        e_fr      = 1'b0;
        if (inst == 0) start_a = 1'b1; else start_b = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        start_b = 1'b0;
        check_val({tag, "_busy_rise"}, 32'(inst == 0 ? busy_a : busy_b), 32'd1);
        check_val({tag, "_done_clr"},  32'(inst == 0 ? done_a : done_b), 32'd0);
        check_val({tag, "_err_clr"},   inst == 0 ? 32'(err_a) : 32'(err_b), 32'd0);
        check_val({tag, "_mm_clr"},    32'(inst == 0 ? mm_a : mm_b), 32'd0);
        for (int c = 0; c < 2000; c++) begin
            obs_busy = (inst == 0) ? busy_a : busy_b;
            if (!obs_busy) break;
            busy_n++;
            check_val({tag, "_stim"}, 32'(inst == 0 ? stim_a : stim_b), 32'(m[1:0]));
            if (c == rst_at) begin
                rst_n = 1'b0;
                #1;
                check_reset({tag, "_midrst"});
                inj_a = 1'b0;
                mm_q.delete();
                return;
            end
            inj = 1'b0;
            if (c >= W) begin
                idx  = c - W;
                inj  = inj_for(mode, idx);
                refv = ^m[1:0];
                if (inj && !prev) begin
                    if (exp_err < errmax) exp_err++;
                    if (first_idx < 0) begin
                        first_idx = idx;
                        e_fd      = ~refv;
                        e_fr      = refv;
                    end
                end
                prev = inj;
                mm_q.push_back(inj);
            end
            if (inst == 0) begin
                inj_a   = inj;
                start_a = (c == pulse_at);
            end else begin
                inj_b   = inj;
                start_b = (c == pulse_at);
            end
            @(posedge clk); #1;
            if (c >= W && mm_q.size() > 0)
                check_val({tag, "_mismatch"}, 32'(inst == 0 ? mm_a : mm_b), 32'(mm_q.pop_front()));
            m = lfsr_next(m);
        end
        inj_a   = 1'b0;
        inj_b   = 1'b0;
        start_a = 1'b0;
        start_b = 1'b0;
        check_val({tag, "_busy_len"}, 32'(busy_n), 32'(W + R));
        check_val({tag, "_done"}, 32'(inst == 0 ? done_a : done_b), 32'd1);
        check_val({tag, "_pass"}, 32'(inst == 0 ? pass_a : pass_b), 32'(exp_err == 0));
        check_val({tag, "_err"},  inst == 0 ? 32'(err_a) : 32'(err_b), 32'(exp_err));
`ifdef FPGA_VERIF_FIRST_ERR_EN
        e_fec = (first_idx < 0) ? 32'd0 : 32'(first_idx);
`else
        e_fec = 32'd0;
        e_fd  = 1'b0;
        e_fr  = 1'b0;
`endif
        check_val({tag, "_fec"},  32'(inst == 0 ? fec_a : fec_b), e_fec);
        check_val({tag, "_fdut"}, 32'(inst == 0 ? fdut_a : fdut_b), 32'(e_fd));
        check_val({tag, "_fref"}, 32'(inst == 0 ? fref_a : fref_b), 32'(e_fr));
        @(posedge clk); #1;
        check_val({tag, "_done_hold"}, 32'(inst == 0 ? done_a : done_b), 32'd1);
        check_val({tag, "_err_hold"},  inst == 0 ? 32'(err_a) : 32'(err_b), 32'(exp_err));
    endtask

    initial begin
        rst_n   = 1'b0;
        start_a = 1'b0;
        start_b = 1'b0;
        inj_a   = 1'b0;
        inj_b   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset("rst");
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_reset("idle");

        run("clean",   0, 0, -1, -1);
        run("burst",   0, 1, -1, -1);
        run("isol",    0, 2, W + 50, -1);
        run("abort",   0, 2, -1, W + 100);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_reset("post_rst");
        run("after",   0, 0, -1, -1);
        run("sat1",    1, 3, -1, -1);
        run("sat2",    1, 3, -1, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
